// File: rtl/win_led_ctrl.sv
// win_led_ctrl: RGB status LED driver for the 3-in-a-row game.
// Maps the 2-bit win code to a one-hot colour. Each new result blinks for
// BLINK_TOGGLES half-periods of BLINK_DIV cycles, then holds solid.
// Optional PWM brightness stage is built when WIN_LED_PWM_EN is defined;
// without it the brightness port is ignored and lit phases drive full on.
module win_led_ctrl #(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned BLINK_DIV     = 50_000_000,
    parameter int unsigned BLINK_TOGGLES = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          detect_win,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [2:0]          LED_out,
    output logic                busy
);

    localparam int unsigned DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned TOG_W = $clog2(BLINK_TOGGLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
    localparam logic [TOG_W-1:0] TOG_DONE = TOG_W'(BLINK_TOGGLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLINK = 2'd1,
        SOLID = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [2:0]         colour, colour_n;
    logic [1:0]         code, code_n;
    logic [DIV_W-1:0]   div_cnt, div_n;
    logic [TOG_W-1:0]   tog_cnt, tog_n, tog_inc;
    logic               phase, phase_n;
    logic               start;
    logic               pwm_on;
    logic [2:0]         led_d;
    logic               busy_d;

    // Win code to one-hot RGB colour
    function automatic logic [2:0] code_colour(input logic [1:0] c);
        logic [2:0] rgb;
        case (c)
            2'b01:   rgb = 3'b100;
            2'b10:   rgb = 3'b010;
            2'b11:   rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

`ifdef WIN_LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    // Free-running PWM counter, wraps naturally at full scale
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // All-ones brightness forces 100% duty; zero gives always off
    assign pwm_on = (pwm_cnt < brightness) || (&brightness);
`else
    logic unused_brightness;

    // Brightness has no effect without the PWM stage
    assign unused_brightness = ^brightness;
    assign pwm_on            = 1'b1;
`endif

    // Blink sequencer next-state and counter logic
    always_comb begin
        state_n  = state;
        colour_n = colour;
        code_n   = code;
        div_n    = div_cnt;
        tog_n    = tog_cnt;
        phase_n  = phase;
        start    = 1'b0;
        tog_inc  = tog_cnt + TOG_W'(1);

        case (state)
            IDLE: begin
                if (detect_win != 2'b00) begin
                    start = 1'b1;
                end
            end
            BLINK: begin
                if (detect_win == 2'b00) begin
                    state_n = IDLE;
                    div_n   = '0;
                    tog_n   = '0;
                    phase_n = 1'b0;
                end else if (detect_win != code) begin
                    start = 1'b1;
                end else if (div_cnt == DIV_LAST) begin
                    div_n   = '0;
                    tog_n   = tog_inc;
                    phase_n = ~phase;
                    // Solid always lands lit regardless of toggle parity
                    if (tog_inc == TOG_DONE) begin
                        state_n = SOLID;
                        phase_n = 1'b1;
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            SOLID: begin
                if (detect_win == 2'b00) begin
                    state_n = IDLE;
                    div_n   = '0;
                    tog_n   = '0;
                    phase_n = 1'b0;
                end else if (detect_win != code) begin
                    start = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                div_n   = '0;
                tog_n   = '0;
                phase_n = 1'b0;
            end
        endcase

        // A start (new or changed code) restarts the blink from a lit phase
        if (start) begin
            state_n  = BLINK;
            code_n   = detect_win;
            colour_n = code_colour(detect_win);
            div_n    = '0;
            tog_n    = '0;
            phase_n  = 1'b1;
        end
    end

    // Next-cycle output drive from current sequencer state
    always_comb begin
        led_d  = 3'b000;
        busy_d = 1'b0;
        if (state != IDLE && phase && pwm_on) begin
            led_d = colour;
        end
        if (state == BLINK) begin
            busy_d = 1'b1;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            colour  <= 3'b000;
            code    <= 2'b00;
            div_cnt <= '0;
            tog_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            state   <= state_n;
            colour  <= colour_n;
            code    <= code_n;
            div_cnt <= div_n;
            tog_cnt <= tog_n;
            phase   <= phase_n;
        end
    end

    // Registered LED and busy outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            LED_out <= 3'b000;
            busy    <= 1'b0;
        end else begin
            LED_out <= led_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_win_led_ctrl.sv
// tb_win_led_ctrl: table vectors, directed corner sequences and randomized
// stimulus against a time-since-start reference model of the LED driver.
module tb_win_led_ctrl;

    localparam int unsigned PB  = 2;
    localparam int unsigned DIV = 4;
    localparam int unsigned TOG = 2;
    localparam int          BLINK_LEN = DIV * TOG;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    detect_win;
    logic [PB-1:0] brightness;
    logic [2:0]    LED_out;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Reference model: active flag, accepted code, cycles since start edge
    bit       m_active;
    bit [1:0] m_code;
    int       m_t;
    int       m_pwm;

    logic [2:0] got_led;
    logic       got_busy;

    typedef struct {
        bit       r;
        bit [1:0] dw;
        bit [2:0] led;
        bit       bsy;
    } vec_t;

    vec_t tbl[$];

    win_led_ctrl #(
        .PWM_BITS     (PB),
        .BLINK_DIV    (DIV),
        .BLINK_TOGGLES(TOG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .detect_win(detect_win),
        .brightness(brightness),
        .LED_out   (LED_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic bit [2:0] m_colour(input bit [1:0] c);
        if (c == 2'b01) return 3'b100;
        if (c == 2'b10) return 3'b010;
        if (c == 2'b11) return 3'b001;
        return 3'b000;
    endfunction

    function automatic bit m_pwm_on(input int cnt, input bit [PB-1:0] br);
`ifdef WIN_LED_PWM_EN
        return (cnt < int'(br)) || (br == {PB{1'b1}});
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare outputs after the edge
    task automatic step(input bit r, input bit [1:0] dw, input bit [PB-1:0] br);
        bit       lit;
        bit [2:0] e_led;
        bit       e_busy;
        reset      = r;
        detect_win = dw;
        brightness = br;
        lit    = (m_t >= BLINK_LEN) || (((m_t / int'(DIV)) % 2) == 0);
        e_led  = (m_active && lit && m_pwm_on(m_pwm, br)) ? m_colour(m_code) : 3'b000;
        e_busy = m_active && (m_t < BLINK_LEN);
        if (r) begin
            e_led = 3'b000; e_busy = 1'b0;
            m_active = 1'b0; m_code = 2'b00; m_t = 0; m_pwm = 0;
        end else begin
            if (dw == 2'b00) begin
                m_active = 1'b0;
            end else if (!m_active || dw != m_code) begin
                m_active = 1'b1; m_code = dw; m_t = 0;
            end else if (m_t < BLINK_LEN) begin
                m_t++;
            end
            m_pwm = (m_pwm + 1) % (1 << PB);
        end
        @(posedge clk);
        #1;
        got_led  = LED_out;
        got_busy = busy;
        chk("model_led", int'(got_led), int'(e_led));
        chk("model_busy", int'(got_busy), int'(e_busy));
    endtask

    function automatic void add(input bit r, input bit [1:0] dw, input bit [2:0] led,
                                input bit bsy, input int n);
        vec_t v;
        v.r = r; v.dw = dw; v.led = led; v.bsy = bsy;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    initial begin
        int cnt;
        bit [1:0] dw;
        bit [PB-1:0] br;

        reset = 1'b1; detect_win = 2'b00; brightness = '1;
        m_active = 1'b0; m_code = 2'b00; m_t = 0; m_pwm = 0;

        // Reset held with code 01, release, blink, solid, clear, new code 10
        add(1'b1, 2'b01, 3'b000, 1'b0, 3);
        add(1'b0, 2'b01, 3'b000, 1'b0, 1);
        add(1'b0, 2'b01, 3'b100, 1'b1, 4);
        add(1'b0, 2'b01, 3'b000, 1'b1, 4);
        add(1'b0, 2'b01, 3'b100, 1'b0, 2);
        add(1'b0, 2'b00, 3'b100, 1'b0, 1);
        add(1'b0, 2'b00, 3'b000, 1'b0, 1);
        add(1'b0, 2'b10, 3'b000, 1'b0, 1);
        add(1'b0, 2'b10, 3'b010, 1'b1, 4);
        add(1'b0, 2'b10, 3'b000, 1'b1, 4);
        add(1'b0, 2'b10, 3'b010, 1'b0, 2);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].dw, 2'b11);
            chk($sformatf("tbl_led[%0d]", i), int'(got_led), int'(tbl[i].led));
            chk($sformatf("tbl_busy[%0d]", i), int'(got_busy), int'(tbl[i].bsy));
        end

        // Reset mid-blink clears outputs on that edge
        step(1'b0, 2'b11, 2'b11);
        step(1'b0, 2'b11, 2'b11);
        step(1'b1, 2'b11, 2'b11);
        chk("rst_mid_led", int'(got_led), 0);
        chk("rst_mid_busy", int'(got_busy), 0);

        // Code 11 to solid, then reduced brightness duty
        for (int i = 0; i < 12; i++) step(1'b0, 2'b11, 2'b11);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'b11, 2'b01);
            if (got_led == 3'b001) cnt++;
        end
`ifdef WIN_LED_PWM_EN
        chk("pwm_quarter_cnt", cnt, 2);
`else
        chk("pwm_quarter_cnt", cnt, 8);
`endif
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'b11, 2'b00);
            if (got_led != 3'b000) cnt++;
        end
`ifdef WIN_LED_PWM_EN
        chk("pwm_zero_cnt", cnt, 0);
`else
        chk("pwm_zero_cnt", cnt, 8);
`endif

        // Code change mid-blink restarts a full sequence with the new colour
        step(1'b0, 2'b00, 2'b11);
        step(1'b0, 2'b00, 2'b11);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 2'b11);
        step(1'b0, 2'b11, 2'b11);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'b11, 2'b11);
            if (i == 0) chk("switch_colour", int'(got_led), 3'b001);
            if (got_busy) cnt++;
        end
        chk("switch_busy_len", cnt, 8);
        step(1'b0, 2'b11, 2'b11);
        chk("switch_busy_end", int'(got_busy), 0);
        chk("switch_solid", int'(got_led), 3'b001);

        // Clear from solid, then the same code blinks again
        step(1'b0, 2'b00, 2'b11);
        step(1'b0, 2'b00, 2'b11);
        chk("clear_led", int'(got_led), 0);
        chk("clear_busy", int'(got_busy), 0);
        step(1'b0, 2'b11, 2'b11);
        step(1'b0, 2'b11, 2'b11);
        chk("reapply_led", int'(got_led), 3'b001);
        chk("reapply_busy", int'(got_busy), 1);

        // Randomized traffic against the model
        dw = 2'b01; br = '1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) dw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) br = PB'($urandom);
            step($urandom_range(0, 99) == 0, dw, br);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/win_led_ctrl.md
# win_led_ctrl

Parametrised win-indicator driver for the RGB status LED of the 3-in-a-row game. It takes the 2-bit win code from win detection and maps it to a one-hot colour. On every new result it blinks the colour for a configurable number of half-periods, then holds it solid. Output brightness is set by a PWM stage. It sits between the win-detection logic and the board's RGB LED pins.

## Interface
Parameters:
- `PWM_BITS`, 8: width of the PWM counter and the `brightness` input.
- `BLINK_DIV`, 50_000_000: clock cycles per blink half-period; must be ≥ 2.
- `BLINK_TOGGLES`, 6: phase toggles before going solid; must be ≥ 1.

Ports:
- `clk`, in, 1: system clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `detect_win`, in, 2: win code.
  - 00: none.
  - 01: player 1.
  - 10: player 2.
  - 11: draw.
- `brightness`, in, `PWM_BITS`: PWM duty; sampled every cycle.
- `LED_out`, out, 3: registered RGB drive.
  - 01 → 100.
  - 10 → 010.
  - 11 → 001.
- `busy`, out, 1: registered; high while in BLINK.

## Operation
- One clock. Synchronous, active-high reset.
- Registers:
  - `state` ∈ {IDLE, BLINK, SOLID}.
  - `colour[2:0]`.
  - `code[1:0]`: last accepted code.
  - `div_cnt`: $clog2(`BLINK_DIV`) bits.
  - `tog_cnt`: $clog2(`BLINK_TOGGLES`+1) bits.
  - `phase`: 1 = lit.
  - `pwm_cnt`: `PWM_BITS` bits, free-running, wraps 2^PWM_BITS−1 → 0.
- "Start", taken on the edge where it occurs:
  - latch `code`=`detect_win` and its colour;
  - `div_cnt`=0, `tog_cnt`=0, `phase`=1;
  - `state`=BLINK.
- IDLE:
  - `detect_win`≠00 → start.
  - Otherwise stay in IDLE.
- BLINK:
  - `detect_win`=00 → IDLE; clear `div_cnt`, `tog_cnt`, `phase`.
  - Else `detect_win`≠`code` → start again (restart blink with new colour).
  - Else `div_cnt` increments. At `div_cnt`=`BLINK_DIV`−1:
    - `div_cnt`=0, `phase` inverts, `tog_cnt`+1;
    - if the new `tog_cnt`=`BLINK_TOGGLES` → SOLID with `phase`=1, whatever the toggle parity.
- SOLID:
  - `detect_win`=00 → IDLE.
  - `detect_win`≠`code` → start.
  - Else hold.
- Priority within a cycle: 00 → IDLE beats a code change, which beats the divider terminal count.
- PWM enable: `pwm_on` = (`pwm_cnt` < `brightness`) OR (`brightness` all ones). All ones gives 100% duty; 0 gives always off.
- Next-cycle output: `LED_out` ← `colour` AND {3{`phase` AND `pwm_on` AND `state`≠IDLE}}.
- Next-cycle busy: `busy` ← (`state`=BLINK).
- An unchanged nonzero code never restarts the blink. Re-entry to BLINK happens only via IDLE or a code change.

## Timing
- Reset values: `LED_out`=000, `busy`=0, `state`=IDLE, all counters 0, `phase`=0, `code`=00, `colour`=000.
- Reset asserted mid-blink or mid-solid: outputs are 000/0 after that edge, whatever else is happening.
- Latency: `detect_win` is nonzero before edge k.
  - `state`=BLINK after edge k.
  - `LED_out` shows the colour after edge k+1, given `pwm_on`.
  - `busy`=1 after edge k+1.
- Each blink half-period lasts exactly `BLINK_DIV` cycles. The first lit half-period starts at the start edge.
- Total blink duration: `BLINK_TOGGLES`×`BLINK_DIV` cycles from the start edge to entry into SOLID.
- Clear: `detect_win`=00 before edge k → `LED_out`=000 after edge k+1.
- `brightness` changes take effect on the next PWM compare. No synchronisation is applied.

## Configuration
- `WIN_LED_PWM_EN` defined:
  - `pwm_cnt` and the comparator are built;
  - `brightness` sets the duty as described above.
- `WIN_LED_PWM_EN` undefined:
  - no PWM counter; `pwm_on` is tied to 1;
  - the `brightness` port remains but is ignored;
  - lit phases drive the colour continuously.

## Test plan
Bench parameters: `BLINK_DIV`=4, `BLINK_TOGGLES`=2, `PWM_BITS`=2, macro defined.
- Reset while `detect_win`=01, held 3 cycles, then released:
  - `LED_out`=000 and `busy`=0 during reset;
  - `LED_out`=100 two edges after release (`brightness`=11).
- `detect_win` 00→10, `brightness`=11:
  - `LED_out` sequence from edge k+1 is 010×4, 000×4, then 010 steady;
  - `busy` is high for 8 cycles, then 0.
- `brightness`=01 in SOLID with code 11:
  - `LED_out`=001 on 1 of every 4 cycles;
  - `brightness`=00 → always 000.
- Code 01 in BLINK, switched to 11 at cycle 5:
  - colour changes to 001 the next output cycle;
  - the blink restarts with a full 8-cycle sequence.
- `detect_win`→00 during SOLID:
  - `LED_out`=000 and `state`=IDLE within 2 edges;
  - reapplying the same code restarts the blink.
- Rebuild without `WIN_LED_PWM_EN`, `brightness`=00, code 01:
  - blink pattern 100/000 as above;
  - then solid 100.
